// File: rtl/icache_pkg.sv
// Shared types and geometry helpers for the direct-mapped instruction cache.
// Address layout: {tag, index, offset} over a 16-bit word address.
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FILL = 2'd2
    } state_t;

    localparam int ADDR_W         = 16;
    localparam int DATA_W         = 16;
    localparam int WORDS_PER_LINE = 4;
    localparam int OFFSET_W       = 2;

    function automatic int idx_w(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tag_w(input int lines);
        return ADDR_W - OFFSET_W - $clog2(lines);
    endfunction

endpackage

// File: rtl/icache_line_store.sv
// Valid/tag/data storage for the instruction cache: combinational read port,
// single-word fill port, tag+valid commit port and a global invalidate.
module icache_line_store
    import icache_pkg::*;
#(
    parameter int LINES = 8,
    localparam int IDX  = idx_w(LINES),
    localparam int TAG  = tag_w(LINES)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inv_all,
    input  logic [IDX-1:0]      rd_idx,
    input  logic [OFFSET_W-1:0] rd_off,
    output logic                rd_valid,
    output logic [TAG-1:0]      rd_tag,
    output logic [DATA_W-1:0]   rd_word,
    input  logic [IDX-1:0]      wr_idx,
    input  logic [OFFSET_W-1:0] wr_off,
    input  logic                wr_word_en,
    input  logic [DATA_W-1:0]   wr_word,
    input  logic                wr_tag_en,
    input  logic [TAG-1:0]      wr_tag,
    input  logic                wr_valid
);

    logic [LINES-1:0]  valid_r;
    logic [TAG-1:0]    tag_r  [0:LINES-1];
    logic [DATA_W-1:0] data_r [0:LINES-1][0:WORDS_PER_LINE-1];

    // Read port: lookup by the fetch index and word offset.
    always_comb begin
        rd_valid = valid_r[rd_idx];
        rd_tag   = tag_r[rd_idx];
        rd_word  = data_r[rd_idx][rd_off];
    end

    // Valid bits; a global invalidate beats a same-cycle line commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= '0;
        end else if (inv_all) begin
            valid_r <= '0;
        end else if (wr_tag_en) begin
            valid_r[wr_idx] <= wr_valid;
        end else begin
            valid_r <= valid_r;
        end
    end

    // Tag and data arrays carry no reset; valid gates every use of them.
    always_ff @(posedge clk) begin
        if (wr_word_en) begin
            data_r[wr_idx][wr_off] <= wr_word;
        end
        if (wr_tag_en) begin
            tag_r[wr_idx] <= wr_tag;
        end
    end

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache: zero-latency hits, blocking
// line refill over a request/grant + beat-valid memory handshake.
module icache_dm
    import icache_pkg::*;
#(
    parameter int LINES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_req,
    input  logic [15:0] pc_addr,
    input  logic        inv_all,
    output logic [15:0] instr,
    output logic        instr_valid,
    output logic        stall,
    output logic        mem_re,
    output logic [15:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [15:0] mem_rdata,
    output logic [15:0] miss_cnt
);

    localparam int IDX = idx_w(LINES);
    localparam int TAG = tag_w(LINES);

    state_t              state_r;
    state_t              state_nxt_s;
    logic [OFFSET_W-1:0] beat_r;
    logic                kill_r;
    logic                mem_re_r;
    logic [15:0]         mem_addr_r;
    logic [15:0]         miss_cnt_r;

    logic [OFFSET_W-1:0] pc_off_s;
    logic [IDX-1:0]      pc_idx_s;
    logic [TAG-1:0]      pc_tag_s;
    logic [IDX-1:0]      fill_idx_s;
    logic [TAG-1:0]      fill_tag_s;

    logic                rd_valid_s;
    logic [TAG-1:0]      rd_tag_s;
    logic [DATA_W-1:0]   rd_word_s;

    logic                hit_s;
    logic                miss_s;
    logic                beat_s;
    logic                last_beat_s;
    logic                commit_valid_s;

    // Address fields of the fetch and of the line being refilled.
    always_comb begin
        pc_off_s   = pc_addr[OFFSET_W-1:0];
        pc_idx_s   = pc_addr[OFFSET_W+IDX-1:OFFSET_W];
        pc_tag_s   = pc_addr[ADDR_W-1:OFFSET_W+IDX];
        fill_idx_s = mem_addr_r[OFFSET_W+IDX-1:OFFSET_W];
        fill_tag_s = mem_addr_r[ADDR_W-1:OFFSET_W+IDX];
    end

    icache_line_store #(
        .LINES (LINES)
    ) u_store (
        .clk        (clk),
        .rst        (rst),
        .inv_all    (inv_all),
        .rd_idx     (pc_idx_s),
        .rd_off     (pc_off_s),
        .rd_valid   (rd_valid_s),
        .rd_tag     (rd_tag_s),
        .rd_word    (rd_word_s),
        .wr_idx     (fill_idx_s),
        .wr_off     (beat_r),
        .wr_word_en (beat_s),
        .wr_word    (mem_rdata),
        .wr_tag_en  (last_beat_s),
        .wr_tag     (fill_tag_s),
        .wr_valid   (commit_valid_s)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; a fill always runs to beat 3 once granted.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (miss_s) begin
                    state_nxt_s = REQ;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    state_nxt_s = FILL;
                end else begin
                    state_nxt_s = REQ;
                end
            end
            FILL: begin
                if (last_beat_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = FILL;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Output logic: hit/miss decode, beat strobes and the pipeline view.
    // inv_all in IDLE suppresses the hit so the fetch is treated as a miss.
    always_comb begin
        hit_s          = (state_r == IDLE) & fetch_req & ~inv_all & rd_valid_s
                         & (rd_tag_s == pc_tag_s);
        miss_s         = (state_r == IDLE) & fetch_req & ~hit_s;
        beat_s         = (state_r == FILL) & mem_rvalid;
        last_beat_s    = beat_s & (beat_r == 2'd3);
        commit_valid_s = ~kill_r & ~inv_all;
        instr_valid    = hit_s;
        stall          = fetch_req & ~hit_s;
        if (hit_s) begin
            instr = rd_word_s;
        end else begin
            instr = 16'h0000;
        end
    end

    // Memory request and line address, held from the miss until the grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_re_r   <= 1'b0;
            mem_addr_r <= 16'h0000;
        end else begin
            mem_re_r <= (state_nxt_s == REQ);
            if (miss_s) begin
                mem_addr_r <= {pc_addr[ADDR_W-1:OFFSET_W], 2'b00};
            end else begin
                mem_addr_r <= mem_addr_r;
            end
        end
    end

    // Beat counter: cleared on grant, advanced on every accepted beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_r <= 2'd0;
        end else if ((state_r == REQ) && mem_gnt) begin
            beat_r <= 2'd0;
        end else if (beat_s) begin
            beat_r <= beat_r + 2'd1;
        end else begin
            beat_r <= beat_r;
        end
    end

    // Kill flag: an invalidate during a refill keeps that line invalid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kill_r <= 1'b0;
        end else if (last_beat_s) begin
            kill_r <= 1'b0;
        end else if (inv_all && (state_r != IDLE)) begin
            kill_r <= 1'b1;
        end else begin
            kill_r <= kill_r;
        end
    end

    // Saturating miss counter, stepped on the edge that leaves IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            miss_cnt_r <= 16'h0000;
        end else if (miss_s && (miss_cnt_r != 16'hFFFF)) begin
            miss_cnt_r <= miss_cnt_r + 16'h0001;
        end else begin
            miss_cnt_r <= miss_cnt_r;
        end
    end

    assign mem_re   = mem_re_r;
    assign mem_addr = mem_addr_r;
    assign miss_cnt = miss_cnt_r;

endmodule

// File: tb/tb_icache_dm.sv
// Directed, table-driven bench for icache_dm: one record per clock cycle
// holding the driven inputs and the hand-computed expected outputs.
module tb_icache_dm;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fetch_req = 1'b0;
    logic [15:0] pc_addr = 16'h0000;
    logic        inv_all = 1'b0;
    logic [15:0] instr;
    logic        instr_valid;
    logic        stall;
    logic        mem_re;
    logic [15:0] mem_addr;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [15:0] mem_rdata = 16'h0000;
    logic [15:0] miss_cnt;

    int total = 0;
    int bad   = 0;

    icache_dm #(.LINES(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_req   (fetch_req),
        .pc_addr     (pc_addr),
        .inv_all     (inv_all),
        .instr       (instr),
        .instr_valid (instr_valid),
        .stall       (stall),
        .mem_re      (mem_re),
        .mem_addr    (mem_addr),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .miss_cnt    (miss_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        r;
        logic        f;
        logic [15:0] pc;
        logic        inv;
        logic        g;
        logic        rv;
        logic [15:0] rd;
        logic [15:0] e_instr;
        logic        e_iv;
        logic        e_stall;
        logic        e_re;
        logic [15:0] e_addr;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic f, input logic [15:0] pc,
                                input logic inv, input logic g, input logic rv,
                                input logic [15:0] rd, input logic [15:0] e_instr,
                                input logic e_iv, input logic e_stall, input logic e_re,
                                input logic [15:0] e_addr, input logic [15:0] e_cnt);
        vec_t v;
        v.r = r; v.f = f; v.pc = pc; v.inv = inv; v.g = g; v.rv = rv; v.rd = rd;
        v.e_instr = e_instr; v.e_iv = e_iv; v.e_stall = e_stall; v.e_re = e_re;
        v.e_addr = e_addr; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string nm, input string fld, input logic [15:0] act,
                       input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s %s actual=%h expected=%h", nm, fld, act, exp);
        end
    endtask

    // Drive one cycle's inputs, check the settled outputs, then clock.
    task automatic step(input string nm, input vec_t v);
        rst = v.r; fetch_req = v.f; pc_addr = v.pc; inv_all = v.inv;
        mem_gnt = v.g; mem_rvalid = v.rv; mem_rdata = v.rd;
        #2;
        chk(nm, "instr",       instr,                  v.e_instr);
        chk(nm, "instr_valid", {15'd0, instr_valid},   {15'd0, v.e_iv});
        chk(nm, "stall",       {15'd0, stall},         {15'd0, v.e_stall});
        chk(nm, "mem_re",      {15'd0, mem_re},        {15'd0, v.e_re});
        chk(nm, "mem_addr",    mem_addr,               v.e_addr);
        chk(nm, "miss_cnt",    miss_cnt,               v.e_cnt);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Cold miss on 0x0005 with an immediately granting memory.
        tbl.push_back(mk(1'b1,1'b0,16'h0000,1'b0,1'b0,1'b0,16'h0000, 16'h0000,1'b0,1'b0,1'b0,16'h0000,16'd0));
        tbl.push_back(mk(1'b0,1'b1,16'h0005,1'b0,1'b0,1'b0,16'h0000, 16'h0000,1'b0,1'b1,1'b0,16'h0000,16'd0));
        tbl.push_back(mk(1'b0,1'b1,16'h0005,1'b0,1'b1,1'b0,16'h0000, 16'h0000,1'b0,1'b1,1'b1,16'h0004,16'd1));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(1'b0,1'b1,16'h0005,1'b0,1'b0,1'b1,16'hA000 + 16'(i), 16'h0000,1'b0,1'b1,1'b0,16'h0004,16'd1));
        tbl.push_back(mk(1'b0,1'b1,16'h0005,1'b0,1'b0,1'b0,16'h0000, 16'hA001,1'b1,1'b0,1'b0,16'h0004,16'd1));
        // Hit sweep across the line.
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(1'b0,1'b1,16'h0004 + 16'(i),1'b0,1'b0,1'b0,16'h0000, 16'hA000 + 16'(i),1'b1,1'b0,1'b0,16'h0004,16'd1));
        tbl.push_back(mk(1'b0,1'b0,16'h0004,1'b0,1'b0,1'b0,16'h0000, 16'h0000,1'b0,1'b0,1'b0,16'h0004,16'd1));
        // Conflict: 0x0024 shares index 1 with 0x0004.
        tbl.push_back(mk(1'b0,1'b1,16'h0024,1'b0,1'b0,1'b0,16'h0000, 16'h0000,1'b0,1'b1,1'b0,16'h0004,16'd1));
        tbl.push_back(mk(1'b0,1'b1,16'h0024,1'b0,1'b1,1'b0,16'h0000, 16'h0000,1'b0,1'b1,1'b1,16'h0024,16'd2));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(1'b0,1'b1,16'h0024,1'b0,1'b0,1'b1,16'hB000 + 16'(i), 16'h0000,1'b0,1'b1,1'b0,16'h0024,16'd2));
        tbl.push_back(mk(1'b0,1'b1,16'h0026,1'b0,1'b0,1'b0,16'h0000, 16'hB002,1'b1,1'b0,1'b0,16'h0024,16'd2));
        tbl.push_back(mk(1'b0,1'b1,16'h0004,1'b0,1'b0,1'b0,16'h0000, 16'h0000,1'b0,1'b1,1'b0,16'h0024,16'd2));
        tbl.push_back(mk(1'b0,1'b1,16'h0004,1'b0,1'b1,1'b0,16'h0000, 16'h0000,1'b0,1'b1,1'b1,16'h0004,16'd3));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(1'b0,1'b1,16'h0004,1'b0,1'b0,1'b1,16'hA000 + 16'(i), 16'h0000,1'b0,1'b1,1'b0,16'h0004,16'd3));
        tbl.push_back(mk(1'b0,1'b1,16'h0004,1'b0,1'b0,1'b0,16'h0000, 16'hA000,1'b1,1'b0,1'b0,16'h0004,16'd3));

        #2;
        for (int i = 0; i < tbl.size(); i++)
            step($sformatf("tbl[%0d]", i), tbl[i]);

        // Slow memory: three grant-wait cycles, stray beat in REQ, gap after beat 1.
        step("slow_miss", mk(1'b0,1'b1,16'h0040,1'b0,1'b0,1'b0,16'h0000, 16'h0000,1'b0,1'b1,1'b0,16'h0004,16'd3));
        step("slow_w1",   mk(1'b0,1'b1,16'h0040,1'b0,1'b0,1'b0,16'h0000, 16'h0000,1'b0,1'b1,1'b1,16'h0040,16'd4));
        step("slow_w2",   mk(1'b0,1'b1,16'h0040,1'b0,1'b0,1'b1,16'hDEAD, 16'h0000,1'b0,1'b1,1'b1,16'h0040,16'd4));
        step("slow_w3",   mk(1'b0,1'b1,16'h0040,1'b0,1'b0,1'b0,16'h0000, 16'h0000,1'b0,1'b1,1'b1,16'h0040,16'd4));
        step("slow_gnt",  mk(1'b0,1'b1,16'h0040,1'b0,1'b1,1'b0,16'h0000, 16'h0000,1'b0,1'b1,1'b1,16'h0040,16'd4));
        step("slow_b0",   mk(1'b0,1'b1,16'h0040,1'b0,1'b0,1'b1,16'hC000, 16'h0000,1'b0,1'b1,1'b0,16'h0040,16'd4));
        step("slow_b1",   mk(1'b0,1'b1,16'h0040,1'b0,1'b0,1'b1,16'hC001, 16'h0000,1'b0,1'b1,1'b0,16'h0040,16'd4));
        step("slow_gap",  mk(1'b0,1'b1,16'h0040,1'b0,1'b0,1'b0,16'h0000, 16'h0000,1'b0,1'b1,1'b0,16'h0040,16'd4));
        step("slow_b2",   mk(1'b0,1'b1,16'h0040,1'b0,1'b0,1'b1,16'hC002, 16'h0000,1'b0,1'b1,1'b0,16'h0040,16'd4));
        step("slow_b3",   mk(1'b0,1'b1,16'h0040,1'b0,1'b0,1'b1,16'hC003, 16'h0000,1'b0,1'b1,1'b0,16'h0040,16'd4));
        step("slow_h2",   mk(1'b0,1'b1,16'h0042,1'b0,1'b0,1'b0,16'h0000, 16'hC002,1'b1,1'b0,1'b0,16'h0040,16'd4));
        step("slow_h1",   mk(1'b0,1'b1,16'h0041,1'b0,1'b0,1'b0,16'h0000, 16'hC001,1'b1,1'b0,1'b0,16'h0040,16'd4));
        step("slow_h3",   mk(1'b0,1'b1,16'h0043,1'b0,1'b0,1'b0,16'h0000, 16'hC003,1'b1,1'b0,1'b0,16'h0040,16'd4));

        // inv_all at beat 1 of line 0x0008: line lands invalid and refetches.
        step("inv_miss",  mk(1'b0,1'b1,16'h0008,1'b0,1'b0,1'b0,16'h0000, 16'h0000,1'b0,1'b1,1'b0,16'h0040,16'd4));
        step("inv_gnt",   mk(1'b0,1'b1,16'h0008,1'b0,1'b1,1'b0,16'h0000, 16'h0000,1'b0,1'b1,1'b1,16'h0008,16'd5));
        step("inv_b0",    mk(1'b0,1'b1,16'h0008,1'b0,1'b0,1'b1,16'hD000, 16'h0000,1'b0,1'b1,1'b0,16'h0008,16'd5));
        step("inv_b1",    mk(1'b0,1'b1,16'h0008,1'b1,1'b0,1'b1,16'hD001, 16'h0000,1'b0,1'b1,1'b0,16'h0008,16'd5));
        step("inv_b2",    mk(1'b0,1'b1,16'h0008,1'b0,1'b0,1'b1,16'hD002, 16'h0000,1'b0,1'b1,1'b0,16'h0008,16'd5));
        step("inv_b3",    mk(1'b0,1'b1,16'h0008,1'b0,1'b0,1'b1,16'hD003, 16'h0000,1'b0,1'b1,1'b0,16'h0008,16'd5));
        step("inv_remiss",mk(1'b0,1'b1,16'h0008,1'b0,1'b0,1'b0,16'h0000, 16'h0000,1'b0,1'b1,1'b0,16'h0008,16'd5));
        step("inv_regnt", mk(1'b0,1'b1,16'h0008,1'b0,1'b1,1'b0,16'h0000, 16'h0000,1'b0,1'b1,1'b1,16'h0008,16'd6));
        for (int i = 0; i < 4; i++)
            step("inv_refill", mk(1'b0,1'b1,16'h0008,1'b0,1'b0,1'b1,16'hE000 + 16'(i), 16'h0000,1'b0,1'b1,1'b0,16'h0008,16'd6));
        step("inv_hit",   mk(1'b0,1'b1,16'h000B,1'b0,1'b0,1'b0,16'h0000, 16'hE003,1'b1,1'b0,1'b0,16'h0008,16'd6));
        step("inv_lost",  mk(1'b0,1'b1,16'h0040,1'b0,1'b0,1'b0,16'h0000, 16'h0000,1'b0,1'b1,1'b0,16'h0008,16'd6));

        // Reset at beat 2 of the 0x0040 refill.
        step("rst_gnt",   mk(1'b0,1'b1,16'h0040,1'b0,1'b1,1'b0,16'h0000, 16'h0000,1'b0,1'b1,1'b1,16'h0040,16'd7));
        step("rst_b0",    mk(1'b0,1'b1,16'h0040,1'b0,1'b0,1'b1,16'hF000, 16'h0000,1'b0,1'b1,1'b0,16'h0040,16'd7));
        step("rst_b1",    mk(1'b0,1'b1,16'h0040,1'b0,1'b0,1'b1,16'hF001, 16'h0000,1'b0,1'b1,1'b0,16'h0040,16'd7));
        step("rst_b2",    mk(1'b1,1'b1,16'h0040,1'b0,1'b0,1'b1,16'hF002, 16'h0000,1'b0,1'b1,1'b0,16'h0000,16'd0));
        step("rst_b3",    mk(1'b0,1'b1,16'h0040,1'b0,1'b0,1'b1,16'hF003, 16'h0000,1'b0,1'b1,1'b0,16'h0000,16'd0));
        step("rst_regnt", mk(1'b0,1'b1,16'h0040,1'b0,1'b1,1'b0,16'h0000, 16'h0000,1'b0,1'b1,1'b1,16'h0040,16'd1));
        for (int i = 0; i < 4; i++)
            step("rst_refill", mk(1'b0,1'b1,16'h0040,1'b0,1'b0,1'b1,16'h1110 + 16'(i), 16'h0000,1'b0,1'b1,1'b0,16'h0040,16'd1));
        step("rst_hit",   mk(1'b0,1'b1,16'h0040,1'b0,1'b0,1'b0,16'h0000, 16'h1110,1'b1,1'b0,1'b0,16'h0040,16'd1));

        // inv_all with fetch_req in IDLE forces a miss on a resident line.
        step("idle_inv",  mk(1'b0,1'b1,16'h0040,1'b1,1'b0,1'b0,16'h0000, 16'h0000,1'b0,1'b1,1'b0,16'h0040,16'd1));
        step("idle_req",  mk(1'b0,1'b1,16'h0040,1'b0,1'b1,1'b0,16'h0000, 16'h0000,1'b0,1'b1,1'b1,16'h0040,16'd2));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
